// File: rtl/alu_cdb_stage.sv
// alu_cdb_stage: integer ALU execution stage feeding the common data bus.
// Ops accepted from the reservation station are evaluated in the same cycle.
// Each {tag,result} pair is queued in a small FIFO. The FIFO head drains onto
// the CDB under a req/grant handshake. A ROB flush discards the whole queue.
//
// Handshake semantics:
//  RS side : an op transfers on a rising edge when in_rs_valid=1 and
//            out_rs_full=0 (with rdy=1, no flush, non-zero tag). The RS must
//            hold its op while out_rs_full=1.
//  CDB side: the head transfers on a rising edge when out_cdb_req=1 and
//            in_cdb_grant=1 (with rdy=1, no flush). A grant without a request
//            has no effect. out_cdb_tag/value are valid whenever out_cdb_req=1
//            and read as zero otherwise.
module alu_cdb_stage #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             in_rob_clear,
  input  logic             in_rs_valid,
  input  logic [OP_W-1:0]  in_rs_op,
  input  logic [31:0]      in_rs_value1,
  input  logic [31:0]      in_rs_value2,
  input  logic [TAG_W-1:0] in_rs_rob_tag,
  output logic             out_rs_full,
  output logic             out_cdb_req,
  input  logic             in_cdb_grant,
  output logic [TAG_W-1:0] out_cdb_tag,
  output logic [31:0]      out_cdb_value
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(9);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [31:0]      val_mem_q [DEPTH];

  logic        empty;
  logic        accept;
  logic        pop;
  logic [4:0]  shamt;
  logic [31:0] alu_result;

  assign empty       = (count_q == '0);
  assign out_rs_full = (count_q == FULL_CNT);
  assign shamt       = in_rs_value2[4:0];

  // Tag 0 means "no destination", so such ops are dropped rather than queued.
  assign accept = rdy & in_rs_valid & ~out_rs_full & ~in_rob_clear
                & (in_rs_rob_tag != '0);
  assign pop    = rdy & ~empty & in_cdb_grant & ~in_rob_clear;

  // Integer ALU; undefined opcodes produce 0 but are still queued.
  always_comb begin
    alu_result = '0;
    case (in_rs_op)
      OP_ADD:  alu_result = in_rs_value1 + in_rs_value2;
      OP_SUB:  alu_result = in_rs_value1 - in_rs_value2;
      OP_AND:  alu_result = in_rs_value1 & in_rs_value2;
      OP_OR:   alu_result = in_rs_value1 | in_rs_value2;
      OP_XOR:  alu_result = in_rs_value1 ^ in_rs_value2;
      OP_SLL:  alu_result = in_rs_value1 << shamt;
      OP_SRL:  alu_result = in_rs_value1 >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(in_rs_value1) >>> shamt);
      OP_SLT:  alu_result = {31'b0, ($signed(in_rs_value1) < $signed(in_rs_value2))};
      OP_SLTU: alu_result = {31'b0, (in_rs_value1 < in_rs_value2)};
      default: alu_result = '0;
    endcase
  end

  // Pointer/count next state; flush wins over push and pop, rdy=0 freezes all.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rdy) begin
      if (in_rob_clear) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({accept, pop})
          2'b10:   count_d = count_q + (PTR_W+1)'(1);
          2'b01:   count_d = count_q - (PTR_W+1)'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Result storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem_q[wr_ptr_q] <= in_rs_rob_tag;
      val_mem_q[wr_ptr_q] <= alu_result;
    end
  end

  // Head is forced to zero when empty so the CDB never sees a stale tag.
  always_comb begin
    out_cdb_req   = ~empty;
    out_cdb_tag   = '0;
    out_cdb_value = '0;
    if (!empty) begin
      out_cdb_tag   = tag_mem_q[rd_ptr_q];
      out_cdb_value = val_mem_q[rd_ptr_q];
    end
  end

endmodule
